// File: rtl/mips_pkg.sv
// Shared opcode, FSM-state and sizing constants for the MIPS fetch path.
package mips_pkg;

    localparam logic [5:0] OP_J   = 6'h02;
    localparam logic [5:0] OP_BEQ = 6'h04;
    localparam logic [5:0] OP_BNE = 6'h05;

    localparam logic [1:0] S_BOOT = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HALT = 2'd2;

    localparam int WORD_BYTES = 4;

    // Branch displacement in bytes: sign-extended word offset, shifted by 2.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC decode: sequential, beq/bne and j targets.
module next_pc_calc
    import mips_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] instr,
    input  logic        alu_zero,
    output logic [31:0] next_pc,
    output logic [31:0] pc_plus4,
    output logic        is_branch_taken,
    output logic        is_jump
);

    logic [5:0] opcode;

    assign pc_plus4 = pc + 32'(WORD_BYTES);
    assign opcode   = instr[31:26];

    // Unknown opcodes or flags fall through to the default, so the
    // sequential path is taken whenever the decode is not definite.
    always_comb begin
        is_branch_taken = 1'b0;
        is_jump         = 1'b0;
        case (opcode)
            OP_BEQ:  if (alu_zero)  is_branch_taken = 1'b1;
            OP_BNE:  if (!alu_zero) is_branch_taken = 1'b1;
            OP_J:    is_jump = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        next_pc = pc_plus4;
        if (is_jump)
            next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
        else if (is_branch_taken)
            next_pc = pc_plus4 + branch_offset(instr[15:0]);
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register, boot/run/halt sequencing and run/retire counters for the
// single-cycle MIPS core; pc_out addresses the instruction ROM.
module pc_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          ROM_WORDS = 32
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] instr_in,
    input  logic        alu_zero,
    input  logic        stall,
    input  logic        halt_req,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4,
    output logic        fetch_valid,
    output logic        halted,
    output logic [31:0] cycle_count,
    output logic [31:0] instr_count
);

    localparam logic [32:0] PC_LIMIT = 33'(ROM_WORDS * WORD_BYTES);

    logic [1:0]  state;
    logic [31:0] next_pc;
    logic        is_branch_taken;
    logic        is_jump;
    logic        out_of_range;
    logic        unused_decode;

    next_pc_calc u_next_pc (
        .pc              (pc_out),
        .instr           (instr_in),
        .alu_zero        (alu_zero),
        .next_pc         (next_pc),
        .pc_plus4        (pc_plus4),
        .is_branch_taken (is_branch_taken),
        .is_jump         (is_jump)
    );

    assign unused_decode = is_branch_taken ^ is_jump;

    // Compared in 33 bits so a backwards branch wrapping below zero is
    // caught as out of range rather than as a small address.
    assign out_of_range = {1'b0, next_pc} >= PC_LIMIT;

    assign fetch_valid = (state == S_RUN);
    assign halted      = (state == S_HALT);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= S_BOOT;
            pc_out      <= RESET_PC;
            cycle_count <= 32'd0;
            instr_count <= 32'd0;
        end else begin
            case (state)
                S_BOOT: state <= S_RUN;
                S_RUN: begin
                    cycle_count <= cycle_count + 32'd1;
                    if (stall) begin
                        if (halt_req)
                            state <= S_HALT;
                    end else begin
                        instr_count <= instr_count + 32'd1;
                        if (!out_of_range)
                            pc_out <= next_pc;
                        if (out_of_range || halt_req)
                            state <= S_HALT;
                    end
                end
                default: state <= S_HALT;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Table-driven check of pc_fetch_unit with a queue scoreboard plus reset/boot sequences.
module tb_pc_fetch_unit;

    logic        clk;
    logic        rstn;
    logic [31:0] instr_in;
    logic        alu_zero;
    logic        stall;
    logic        halt_req;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic        fetch_valid;
    logic        halted;
    logic [31:0] cycle_count;
    logic [31:0] instr_count;

    pc_fetch_unit #(.RESET_PC(32'h0), .ROM_WORDS(32)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .instr_in    (instr_in),
        .alu_zero    (alu_zero),
        .stall       (stall),
        .halt_req    (halt_req),
        .pc_out      (pc_out),
        .pc_plus4    (pc_plus4),
        .fetch_valid (fetch_valid),
        .halted      (halted),
        .cycle_count (cycle_count),
        .instr_count (instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_before;
        logic [31:0] instr;
        logic        az;
        logic        st;
        logic        hq;
        logic [31:0] pc;
        logic        h;
        logic [31:0] ic;
        logic [31:0] cc;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic        h;
        logic        fv;
        logic [31:0] ic;
        logic [31:0] cc;
    } exp_t;

    localparam logic [31:0] NOP = 32'h0000_0020;
    localparam int NV = 29;

    vec_t vt[NV];
    exp_t sb[$];
    int tests = 0;
    int fails = 0;

    function automatic vec_t mk(input logic r, input logic [31:0] i, input logic az,
                                input logic st, input logic hq, input logic [31:0] pc,
                                input logic h, input int ic, input int cc);
        vec_t v;
        v.rst_before = r; v.instr = i; v.az = az; v.st = st; v.hq = hq;
        v.pc = pc; v.h = h; v.ic = 32'(ic); v.cc = 32'(cc);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Asynchronous reset between edges, checked before any clock, then a
    // boot cycle with halt_req held high (it must be ignored in boot).
    task automatic do_reset();
        @(negedge clk);
        #2;
        rstn = 1'b0;
        #1;
        chk("rst_pc", pc_out, 32'h0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_fv", {31'd0, fetch_valid}, 32'd0);
        chk("rst_ic", instr_count, 32'd0);
        chk("rst_cc", cycle_count, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        instr_in = NOP; alu_zero = 1'b0; stall = 1'b0; halt_req = 1'b1;
        rstn = 1'b1;
        #1;
        chk("boot_fv", {31'd0, fetch_valid}, 32'd0);
        chk("boot_pc", pc_out, 32'h0);
        @(posedge clk);
        #1;
        chk("run_fv", {31'd0, fetch_valid}, 32'd1);
        chk("run_halted", {31'd0, halted}, 32'd0);
        chk("run_pc", pc_out, 32'h0);
        chk("run_cc", cycle_count, 32'd0);
    endtask

    initial begin
        rstn = 1'b0; instr_in = NOP; alu_zero = 1'b0; stall = 1'b0; halt_req = 1'b0;

        // Sequential, stall, beq/bne/j, stalled branch, backwards branch.
        vt[0]  = mk(1, NOP,           0, 0, 0, 32'h04, 0,  1,  1);
        vt[1]  = mk(0, NOP,           0, 0, 0, 32'h08, 0,  2,  2);
        vt[2]  = mk(0, NOP,           0, 1, 0, 32'h08, 0,  2,  3);
        vt[3]  = mk(0, NOP,           0, 1, 0, 32'h08, 0,  2,  4);
        vt[4]  = mk(0, NOP,           0, 1, 0, 32'h08, 0,  2,  5);
        vt[5]  = mk(0, NOP,           0, 0, 0, 32'h0C, 0,  3,  6);
        vt[6]  = mk(0, 32'h08000006,  0, 0, 0, 32'h18, 0,  4,  7);
        vt[7]  = mk(0, 32'h10A10002,  1, 0, 0, 32'h24, 0,  5,  8);
        vt[8]  = mk(0, 32'h14220002,  0, 0, 0, 32'h30, 0,  6,  9);
        vt[9]  = mk(0, 32'h08000006,  0, 0, 0, 32'h18, 0,  7, 10);
        vt[10] = mk(0, 32'h10A10002,  0, 0, 0, 32'h1C, 0,  8, 11);
        vt[11] = mk(0, 32'h0800000A,  0, 0, 0, 32'h28, 0,  9, 12);
        vt[12] = mk(0, 32'h0800000D,  0, 0, 0, 32'h34, 0, 10, 13);
        vt[13] = mk(0, 32'h14220002,  1, 0, 0, 32'h38, 0, 11, 14);
        vt[14] = mk(0, 32'h10A10002,  1, 1, 0, 32'h38, 0, 11, 15);
        vt[15] = mk(0, 32'h1000FFFE,  1, 0, 0, 32'h34, 0, 12, 16);
        // Mid-run reset at 0x34, then range halt at 0x7C and frozen state.
        vt[16] = mk(1, 32'h0800001F,  0, 0, 0, 32'h7C, 0,  1,  1);
        vt[17] = mk(0, NOP,           0, 0, 0, 32'h7C, 1,  2,  2);
        vt[18] = mk(0, NOP,           0, 0, 0, 32'h7C, 1,  2,  2);
        vt[19] = mk(0, 32'h08000000,  0, 0, 1, 32'h7C, 1,  2,  2);
        // halt_req together with stall at 0x10.
        vt[20] = mk(1, NOP,           0, 0, 0, 32'h04, 0,  1,  1);
        vt[21] = mk(0, NOP,           0, 0, 0, 32'h08, 0,  2,  2);
        vt[22] = mk(0, NOP,           0, 0, 0, 32'h0C, 0,  3,  3);
        vt[23] = mk(0, NOP,           0, 0, 0, 32'h10, 0,  4,  4);
        vt[24] = mk(0, NOP,           0, 1, 1, 32'h10, 1,  4,  5);
        vt[25] = mk(0, NOP,           0, 0, 0, 32'h10, 1,  4,  5);
        // halt_req without stall retires and takes the jump.
        vt[26] = mk(1, 32'h08000010,  0, 0, 1, 32'h40, 1,  1,  1);
        vt[27] = mk(0, NOP,           0, 0, 0, 32'h40, 1,  1,  1);
        // Backwards branch from 0 wraps to 0xFFFFFFFC: out of range.
        vt[28] = mk(1, 32'h1000FFFE,  1, 0, 0, 32'h00, 1,  1,  1);

        for (int k = 0; k < NV; k++) begin
            exp_t e;
            if (vt[k].rst_before) do_reset();
            @(negedge clk);
            instr_in = vt[k].instr; alu_zero = vt[k].az;
            stall = vt[k].st; halt_req = vt[k].hq;
            e.pc = vt[k].pc; e.h = vt[k].h; e.fv = !vt[k].h;
            e.ic = vt[k].ic; e.cc = vt[k].cc;
            sb.push_back(e);
            @(posedge clk);
            #1;
            if (sb.size() == 0) begin
                tests++; fails++;
                $display("FAIL scoreboard_empty: got 0 entries expected 1 at vec %0d", k);
            end else begin
                e = sb.pop_front();
                chk($sformatf("v%0d_pc", k), pc_out, e.pc);
                chk($sformatf("v%0d_halted", k), {31'd0, halted}, {31'd0, e.h});
                chk($sformatf("v%0d_fv", k), {31'd0, fetch_valid}, {31'd0, e.fv});
                chk($sformatf("v%0d_ic", k), instr_count, e.ic);
                chk($sformatf("v%0d_cc", k), cycle_count, e.cc);
                chk($sformatf("v%0d_pc4", k), pc_plus4, e.pc + 32'd4);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
